// File: rtl/cic_pkg.sv
// Shared CIC constants and small elaboration helpers. Used by the
// decimator, the integrators and the comb section.
package cic_pkg;

  // Data path width shared by integrators, decimator and comb
  localparam int CIC_W          = 17;
  // Rate change applied by the decimator
  localparam int CIC_DECIM      = 5;
  // Default filter order and differential delay
  localparam int CIC_STAGES     = 3;
  localparam int CIC_DIFF_DELAY = 1;

  // Legal ranges for the comb section
  localparam int CIC_MIN_STAGES = 1;
  localparam int CIC_MAX_STAGES = 6;
  localparam int CIC_MIN_DELAY  = 1;
  localparam int CIC_MAX_DELAY  = 2;

  // Number of comb outputs that still see the all-zero reset history.
  // The output after this many rdy pulses is the first clean one.
  function automatic int settle_len(input int stages, input int delay);
    return stages * delay;
  endfunction

  // Counter width able to hold 0..n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cic_comb_if.sv
// Sample/strobe bundle between the decimator (master) and the comb
// section (slave).
interface cic_comb_if
  import cic_pkg::*;
#(
  parameter int IN_W  = CIC_W,
  parameter int OUT_W = CIC_W
);

  logic [IN_W-1:0]  din;
  logic             din_rdy;
  logic [OUT_W-1:0] dout;
  logic             rdy;
  logic             settled;

  // Upstream side: drives samples, observes filtered output
  modport master (
    output din,
    output din_rdy,
    input  dout,
    input  rdy,
    input  settled
  );

  // Comb side: consumes samples, produces filtered output
  modport slave (
    input  din,
    input  din_rdy,
    output dout,
    output rdy,
    output settled
  );

endinterface

// File: rtl/cic_comb_stage.sv
// One comb differentiator y[n] = x[n] - x[n-DIFF_DELAY].
// Everything (output and delay line) advances only on en, so idle
// high-rate clocks between decimated samples never disturb the history.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W          = CIC_W,
  parameter int DIFF_DELAY = CIC_DIFF_DELAY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         vld
);

  // dl[0] holds the newest past sample, dl[DIFF_DELAY-1] the oldest
  logic [DIFF_DELAY-1:0][W-1:0] dl;

  // Differentiate and shift the delay line on fire; valid follows en by one clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl  <= '0;
      y   <= '0;
      vld <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        // Plain modulo-2^W subtraction: wrap is exact for CIC
        y     <= x - dl[DIFF_DELAY-1];
        dl[0] <= x;
        for (int i = 1; i < DIFF_DELAY; i++) begin
          dl[i] <= dl[i-1];
        end
      end
    end
  end

endmodule

// File: rtl/cic_comb.sv
// Comb section of the decimating CIC filter: STAGES cascaded
// differentiators at the low rate, output scaling to OUT_W, and a
// sticky settled flag once the reset history has flushed out.
module cic_comb
  import cic_pkg::*;
#(
  parameter int IN_W       = CIC_W,
  parameter int OUT_W      = CIC_W,
  parameter int STAGES     = CIC_STAGES,
  parameter int DIFF_DELAY = CIC_DIFF_DELAY
) (
  input  logic      clk,
  input  logic      rst,
  cic_comb_if.slave bus
);

  localparam int SETTLE_N = settle_len(STAGES, DIFF_DELAY);
  localparam int CNT_W    = cnt_width(SETTLE_N);

  // Reject unsupported configurations at elaboration
  if (OUT_W > IN_W || OUT_W < 1) begin : g_bad_out_w
    $error("cic_comb: OUT_W must be in 1..IN_W");
  end
  if (STAGES < CIC_MIN_STAGES || STAGES > CIC_MAX_STAGES) begin : g_bad_stages
    $error("cic_comb: STAGES out of range");
  end
  if (DIFF_DELAY < CIC_MIN_DELAY || DIFF_DELAY > CIC_MAX_DELAY) begin : g_bad_delay
    $error("cic_comb: DIFF_DELAY out of range");
  end

  // Entry k is the input of stage k; entry STAGES is the last stage output
  logic [STAGES:0][IN_W-1:0] data_pipe;
  logic [STAGES:0]           vld_pipe;

  assign data_pipe[0] = bus.din;
  assign vld_pipe[0]  = bus.din_rdy;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cic_comb_stage #(
      .W          (IN_W),
      .DIFF_DELAY (DIFF_DELAY)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .en  (vld_pipe[k]),
      .x   (data_pipe[k]),
      .y   (data_pipe[k+1]),
      .vld (vld_pipe[k+1])
    );
  end

  logic [OUT_W-1:0] dout_q;
  logic             rdy_q;
  logic             settled_q;
  logic [CNT_W-1:0] cnt;

  // Output register: arithmetic shift right by IN_W-OUT_W then truncate
  // to OUT_W is exactly the top OUT_W bits (floor, no rounding)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        dout_q <= data_pipe[STAGES][IN_W-1 -: OUT_W];
      end
    end
  end

  // Count outputs up to SETTLE_N; the next one after that is clean, and
  // settled rises on the same edge as that rdy and stays up
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      settled_q <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      if (cnt == CNT_W'(SETTLE_N)) begin
        settled_q <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.dout    = dout_q;
  assign bus.rdy     = rdy_q;
  assign bus.settled = settled_q;

endmodule

// File: doc/cic_comb.md
Name: cic_comb

Overview:
- Comb section of the decimating CIC filter. Sits directly downstream of the decimation stage.
- Consumes the decimated 17-bit sample and its one-clock ready strobe.
- Applies STAGES cascaded differentiators y[n] = x[n] - x[n-DIFF_DELAY] at the low rate, then scales the result to the output width.
- Provides a settled flag so that start-up transient samples can be discarded downstream.

Parameters:
- IN_W, 17, input and internal width; matches the integrator/decimator data width.
- OUT_W, 17, output width. Must satisfy OUT_W <= IN_W; elaboration fails otherwise.
- STAGES, 3, number of comb stages; range 1..6.
- DIFF_DELAY, 1, differential delay M per stage; range 1..2.

Ports:
- clk  in  1  system clock (high-rate clock, same as the decimator).
- rst  in  1  asynchronous reset, active-high.
- din  in  IN_W  signed decimated sample; sampled only when din_rdy=1.
- din_rdy  in  1  one-clock valid strobe from the decimator.
- dout  out  OUT_W  signed filtered output; held between strobes.
- rdy  out  1  one-clock pulse when dout is updated.
- settled  out  1  high once dout depends only on real input samples; sticky until reset.

Behaviour:
- Reset (async, rst=1): all stage registers, delay lines, dout, rdy, settled and the settle counter clear to 0. Effect is immediate, not at a clock edge.
- Pipeline: one register per stage plus a per-stage valid bit v[k].
  - Stage 0 fires on din_rdy; stage k fires when v[k-1]=1.
  - A stage updates its output register and its delay line only when it fires; otherwise it holds.
  - The delay line per stage is DIFF_DELAY words, shifted only on that stage's fire, never on idle clocks.
- Arithmetic:
  - Differences are taken modulo 2^IN_W. Two's-complement wrap is intended; there is no saturation and no overflow flag.
  - This is exact for CIC as long as the upstream integrators use the same width.
- Output scaling: dout = final stage value arithmetically shifted right by (IN_W-OUT_W). Truncation toward minus infinity, no rounding. When OUT_W=IN_W, dout passes unchanged.
- Latency:
  - rdy asserts exactly STAGES clocks after the din_rdy edge that sampled the input.
  - dout changes on the same edge as rdy and holds until the next rdy.
- Throughput: accepts din_rdy on every clock, back-to-back, with no stall. There is no backpressure; the downstream must take every rdy.
- Settle counter:
  - Counts rdy pulses, saturating at STAGES*DIFF_DELAY.
  - settled goes to 1 on the clock of rdy pulse number STAGES*DIFF_DELAY+1, coinciding with that pulse.
  - settled never deasserts until reset.
- Reset mid-operation: in-flight valid bits are dropped, so no rdy is produced for samples already in the pipe. settled clears and the counter restarts.
- din while din_rdy=0: ignored, and may be X.

Decomposition:
- Shared package cic_pkg holds the CIC constants: data width 17, decimation factor 5, default STAGES=3, default DIFF_DELAY=1. This module, the decimator and the integrator all pull defaults from it.
- One natural sub-module, cic_comb_stage: a single differentiator with an enable, a DIFF_DELAY delay line, and a registered output with valid.
- The top instantiates STAGES of them in a generate loop and adds the scaling and settle logic.

Test Plan:
- Impulse (STAGES=3, M=1, OUT_W=17): din=1 on the first strobe, then 0 on strobes every 5 clocks.
  - Required dout sequence: 1, -3, 3, -1, 0, 0.
  - Each rdy comes 3 clocks after its din_rdy; settled rises with the 4th rdy.
- Step (STAGES=3, M=1): din=100 constant on every strobe.
  - Required dout sequence: 100, -200, 100, 0, 0…
- Wrap (STAGES=1, M=1, IN_W=17): din=65535, then -65536.
  - Second dout = 1, from (-65536-65535) mod 2^17. No saturation occurs.
- Scaling and delay (STAGES=1, M=2, OUT_W=12): strobes with din=1024, 0, 0.
  - dout = 32, 0, -32.
  - settled rises with the 3rd rdy.
- Back-to-back (STAGES=3, M=1): din_rdy held high for 4 clocks with din=1, 0, 0, 0.
  - rdy is high for 4 consecutive clocks, starting 3 clocks after the first strobe.
  - dout values: 1, -3, 3, -1.
- Mid-operation reset: assert rst while 2 samples are in flight and release it.
  - No rdy pulse appears; dout=0 and settled=0.
  - After release, the impulse test reproduces exactly.
